// File: rtl/padd_mp_seq.sv
// Multi-precision adder/subtractor: one 32-bit adder is time-shared across
// NLIMBS limbs, least significant first, one limb per clock.

module p_adder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] s,
    output logic        cout
);
    assign {cout, s} = 33'(a) + 33'(b) + 33'(cin);
endmodule

module padd_mp_seq #(
    parameter int NLIMBS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [32*NLIMBS-1:0] in_a,
    input  logic [32*NLIMBS-1:0] in_b,
    input  logic                 in_sub,
    input  logic                 in_cin,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [32*NLIMBS-1:0] out_sum,
    output logic                 out_cout,
    output logic                 out_ovf,
    output logic                 busy
);
    localparam int W  = 32 * NLIMBS;
    localparam int LW = $clog2(NLIMBS);
    localparam logic [LW-1:0] LAST_LIMB = LW'(NLIMBS - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic          sub_q, sub_d;
    logic [LW-1:0] limb_q, limb_d;
    logic          carry_q, carry_d;
    logic [W-1:0]  sum_q, sum_d;
    logic          cout_q, cout_d;
    logic          ovf_q, ovf_d;

    logic [31:0] add_a, add_b, add_s;
    logic        add_cout;

    // Subtraction is A + ~B + 1: invert each B limb and seed the carry with 1.
    assign add_a = a_q[32*limb_q +: 32];
    assign add_b = sub_q ? ~b_q[32*limb_q +: 32] : b_q[32*limb_q +: 32];

    p_adder u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (carry_q),
        .s    (add_s),
        .cout (add_cout)
    );

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves
        // it unassigned, which would otherwise infer a latch.
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sub_d   = sub_q;
        limb_d  = limb_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    sub_d   = in_sub;
                    limb_d  = '0;
                    carry_d = in_sub | in_cin;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[32*limb_q +: 32] = add_s;
                carry_d = add_cout;
                if (limb_q == LAST_LIMB) begin
                    cout_d  = add_cout;
                    // Operands share a sign that the result does not.
                    ovf_d   = (add_a[31] == add_b[31]) && (add_s[31] != add_a[31]);
                    state_d = DONE;
                end else begin
                    limb_d = limb_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            limb_q  <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            limb_q  <= limb_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;
    assign out_ovf   = ovf_q;
endmodule

// File: tb/tb_padd_mp_seq.sv
// Directed bench for padd_mp_seq with NLIMBS=4: hand-computed vectors,
// latency, backpressure, async reset and mid-operation abort.

module tb_padd_mp_seq;
    localparam int NL = 4;
    localparam int W  = 32 * NL;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_sub;
    logic         in_cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;
    logic         busy;

    int n_cmp = 0;
    int n_bad = 0;

    padd_mp_seq #(.NLIMBS(NL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    // Issues one request and waits for out_valid; lat counts edges after accept.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic sub, input logic cin, output int lat);
        @(negedge clk);
        in_a = a; in_b = b; in_sub = sub; in_cin = cin; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        // Scramble operands after accept; the operation in flight must not see it.
        in_a = {4{32'hDEADBEEF}}; in_b = {4{32'h0BADF00D}}; in_sub = ~sub; in_cin = ~cin;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("post_handshake_idle", W'({out_valid, in_ready, busy}), W'(3'b010));
    endtask

    task automatic run_vec(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic sub, input logic cin, input logic [W-1:0] exp_sum,
                           input logic exp_cout, input logic exp_ovf);
        int lat;
        start_op(a, b, sub, cin, lat);
        chk({tag, "_latency"}, W'(lat), W'(NL));
        chk({tag, "_sum"}, out_sum, exp_sum);
        chk({tag, "_cout"}, W'(out_cout), W'(exp_cout));
        chk({tag, "_ovf"}, W'(out_ovf), W'(exp_ovf));
        consume();
    endtask

    initial begin
        int lat;
        logic [W-1:0] held_sum;
        logic saw_valid;

        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
        in_sub = 1'b0; in_cin = 1'b0; out_ready = 1'b0;
        #2;
        chk("reset_state", W'({in_ready, out_valid, busy, out_cout, out_ovf}), W'(5'b10000));
        chk("reset_sum", out_sum, '0);
        #10 rst_n = 1'b1;

        run_vec("wrap", {W{1'b1}}, W'(1), 1'b0, 1'b0, '0, 1'b1, 1'b0);
        run_vec("limb_carry", W'(64'h0000_0000_FFFF_FFFF), W'(1), 1'b0, 1'b0,
                W'(64'h0000_0001_0000_0000), 1'b0, 1'b0);
        run_vec("sub_5_7", W'(5), W'(7), 1'b1, 1'b1, {{(W-4){1'b1}}, 4'hE}, 1'b0, 1'b0);
        run_vec("pos_ovf", {1'b0, {(W-1){1'b1}}}, W'(1), 1'b0, 1'b0,
                {1'b1, {(W-1){1'b0}}}, 1'b0, 1'b1);
        run_vec("sub_no_borrow", W'(100), W'(58), 1'b1, 1'b0, W'(42), 1'b1, 1'b0);
        run_vec("neg_ovf", {1'b1, {(W-1){1'b0}}}, W'(1), 1'b1, 1'b0,
                {1'b0, {(W-1){1'b1}}}, 1'b1, 1'b1);

        // Backpressure: stay in DONE for 3 cycles while in_valid pulses.
        start_op(W'(3), W'(4), 1'b0, 1'b0, lat);
        chk("bp_latency", W'(lat), W'(NL));
        held_sum = out_sum;
        chk("bp_sum", held_sum, W'(7));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_a = W'(1000 + i); in_b = W'(i);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            chk("bp_sum_stable", out_sum, held_sum);
            chk("bp_flags", W'({out_valid, in_ready, busy}), W'(3'b101));
        end
        consume();
        @(negedge clk);
        chk("bp_no_second_accept", W'({busy, in_ready}), W'(2'b01));

        // Leave a result waiting in DONE, then reset asynchronously mid-cycle.
        start_op(W'(9), W'(9), 1'b0, 1'b0, lat);
        chk("async_pre_sum", out_sum, W'(18));
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_reset_flags", W'({in_ready, out_valid, busy}), W'(3'b100));
        chk("async_reset_sum", out_sum, '0);
        #2 rst_n = 1'b1;

        // Abort during RUN limb 2.
        @(negedge clk);
        in_a = {4{32'hFFFF_FFFF}}; in_b = W'(1); in_sub = 1'b0; in_cin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("abort_flags", W'({in_ready, out_valid, busy}), W'(3'b100));
        #2 rst_n = 1'b1;
        saw_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) saw_valid = 1'b1;
        end
        chk("abort_no_valid", W'(saw_valid), W'(0));

        run_vec("after_abort", {4{32'h1234_5678}}, {4{32'h8765_4321}}, 1'b0, 1'b1,
                {32'h9999_9999, 32'h9999_9999, 32'h9999_9999, 32'h9999_999A}, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
